// File: rtl/adder_chunked.sv
// adder_chunked: multi-cycle WIDTH-bit adder/subtractor that handles one
// CHUNK-bit slice per clock, LSB slice first.
//
// Optional feature macro: ADDER_MODRED_EN
//   undefined : IDLE -> PASS1 -> IDLE, result[WIDTH] = carry-out / borrow.
//   defined   : IDLE -> PASS1 -> PASS2 -> IDLE, constant-time modular
//               correction against in_m, result[WIDTH] = 0.
//
// Handshake: start is sampled only while busy=0 (state IDLE). An accepted
// start latches operands and mode; busy rises on that same edge. done pulses
// for exactly one cycle on the edge that writes the final slice, and busy
// falls on that same edge, so start may be raised again in the done cycle.
module adder_chunked #(
    parameter int WIDTH = 384,
    parameter int CHUNK = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH:0]   result,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

`ifdef ADDER_MODRED_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS1 = 2'd1,
        S_PASS2 = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS1 = 2'd1
    } state_t;
`endif

    typedef logic [CHUNK-1:0] slice_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic            carry_q;
    logic            sub_q;
    logic            done_q;
    logic            r_top_q;
    slice_t          a_q [NCHUNK];
    slice_t          b_q [NCHUNK];
    slice_t          r_q [NCHUNK];
    slice_t          a_in [NCHUNK];
    slice_t          b_in [NCHUNK];

`ifdef ADDER_MODRED_EN
    slice_t          m_q  [NCHUNK];
    slice_t          m_in [NCHUNK];
    slice_t          t_q  [NCHUNK];
    logic            c1_q;
    logic            keep_pass2;
`else
    // in_m has no role without modular reduction.
    logic            unused_m;
    assign unused_m = ^in_m;
`endif

    logic            last;
    slice_t          x_sl;
    slice_t          y_raw;
    slice_t          y_sl;
    logic            inv_y;
    logic [CHUNK:0]  sum_ext;
    slice_t          sum_sl;
    logic            cout;

    // Split the wide ports into slices and reassemble the result register.
    for (genvar g = 0; g < NCHUNK; g++) begin : g_slices
        assign a_in[g] = in_a[g*CHUNK +: CHUNK];
        assign b_in[g] = in_b[g*CHUNK +: CHUNK];
`ifdef ADDER_MODRED_EN
        assign m_in[g] = in_m[g*CHUNK +: CHUNK];
`endif
        assign result[g*CHUNK +: CHUNK] = r_q[g];
    end
    assign result[WIDTH] = r_top_q;

    assign last = (cnt_q == CW'(NCHUNK - 1));

    // Slice adder: operand selection per pass, optional inversion, carry-in.
    always_comb begin
        x_sl  = a_q[cnt_q];
        y_raw = b_q[cnt_q];
        inv_y = sub_q;
`ifdef ADDER_MODRED_EN
        if (state_q == S_PASS2) begin
            // add mode corrects with r - m, subtract mode with r + m
            x_sl  = r_q[cnt_q];
            y_raw = m_q[cnt_q];
            inv_y = ~sub_q;
        end
`endif
        y_sl    = inv_y ? ~y_raw : y_raw;
        sum_ext = {1'b0, x_sl} + {1'b0, y_sl} + {{CHUNK{1'b0}}, carry_q};
        sum_sl  = sum_ext[CHUNK-1:0];
        cout    = sum_ext[CHUNK];
    end

`ifdef ADDER_MODRED_EN
    // Keep the corrected value when r >= m (add) or when PASS1 borrowed (sub).
    always_comb begin
        keep_pass2 = sub_q ? ~c1_q : (c1_q | cout);
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_PASS1;
            end
            S_PASS1: begin
`ifdef ADDER_MODRED_EN
                if (last) state_d = S_PASS2;
`else
                if (last) state_d = S_IDLE;
`endif
            end
`ifdef ADDER_MODRED_EN
            S_PASS2: begin
                if (last) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = done_q;
        state_dbg = state_q;
    end

    // Datapath: operand latch, slice counter, carry chain and result slices.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            done_q  <= 1'b0;
            r_top_q <= 1'b0;
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            r_q     <= '{default: '0};
`ifdef ADDER_MODRED_EN
            m_q     <= '{default: '0};
            t_q     <= '{default: '0};
            c1_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
`ifdef ADDER_MODRED_EN
                        m_q     <= m_in;
`endif
                        sub_q   <= subtract;
                        carry_q <= subtract;
                        cnt_q   <= '0;
                    end
                end
                S_PASS1: begin
                    r_q[cnt_q] <= sum_sl;
                    carry_q    <= cout;
                    cnt_q      <= last ? '0 : cnt_q + CW'(1);
                    if (last) begin
`ifdef ADDER_MODRED_EN
                        c1_q    <= cout;
                        carry_q <= ~sub_q;
                        r_top_q <= 1'b0;
`else
                        r_top_q <= cout ^ sub_q;
                        done_q  <= 1'b1;
`endif
                    end
                end
`ifdef ADDER_MODRED_EN
                S_PASS2: begin
                    t_q[cnt_q] <= sum_sl;
                    carry_q    <= cout;
                    cnt_q      <= last ? '0 : cnt_q + CW'(1);
                    if (last) begin
                        done_q  <= 1'b1;
                        r_top_q <= 1'b0;
                        if (keep_pass2) begin
                            r_q             <= t_q;
                            r_q[NCHUNK-1]   <= sum_sl;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_chunked.sv
// Self-checking bench for adder_chunked (default 384/64). Works in both the
// plain build and the ADDER_MODRED_EN build.
module tb_adder_chunked;

    localparam int WIDTH  = 384;
    localparam int CHUNK  = 64;
    localparam int NCHUNK = WIDTH / CHUNK;
`ifdef ADDER_MODRED_EN
    localparam int LAT = 2 * NCHUNK;
`else
    localparam int LAT = NCHUNK;
`endif
    localparam int NVEC = 8;

    typedef logic [WIDTH-1:0] op_t;
    typedef logic [WIDTH:0]   res_t;

    typedef struct {
        logic sub;
        op_t  a;
        op_t  b;
        op_t  m;
        res_t exp;
    } vec_t;

    logic       clk;
    logic       resetn;
    logic       start;
    logic       subtract;
    op_t        in_a;
    op_t        in_b;
    op_t        in_m;
    res_t       result;
    logic       done;
    logic       busy;
    logic [1:0] state_dbg;

    int   checks   = 0;
    int   failures = 0;
    res_t exp_q[$];
    vec_t tbl[NVEC];

    adder_chunked #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .subtract  (subtract),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_m      (in_m),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic check(input string name, input res_t act, input res_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference model: plain wide arithmetic
    function automatic res_t model(input logic sub, input op_t a, input op_t b, input op_t m);
        res_t s;
`ifdef ADDER_MODRED_EN
        if (!sub) begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= {1'b0, m}) s = s - {1'b0, m};
        end else begin
            if (a >= b) s = {1'b0, op_t'(a - b)};
            else        s = {1'b0, op_t'(a - b + m)};
        end
`else
        s = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        if (m == '1) s = s;
`endif
        return s;
    endfunction

    function automatic op_t rand_op();
        op_t v;
        for (int i = 0; i < WIDTH / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic gen_ops(output op_t a, output op_t b, output op_t m);
`ifdef ADDER_MODRED_EN
        m = rand_op() | (op_t'(1) << (WIDTH - 1));
        a = rand_op() % m;
        b = rand_op() % m;
        if ($urandom_range(0, 3) == 0) b = a;
`else
        m = rand_op();
        a = rand_op();
        b = rand_op();
        if ($urandom_range(0, 3) == 0) b = a;
        if ($urandom_range(0, 3) == 0) a = '1;
`endif
    endtask

    task automatic set_vec(input int i, input logic sub, input op_t a, input op_t b,
                           input op_t m, input res_t exp);
        tbl[i].sub = sub;
        tbl[i].a   = a;
        tbl[i].b   = b;
        tbl[i].m   = m;
        tbl[i].exp = exp;
    endtask

    // driver: one-cycle start pulse, returns at the negedge after acceptance
    task automatic start_op(input logic sub, input op_t a, input op_t b, input op_t m);
        @(negedge clk);
        subtract = sub;
        in_a     = a;
        in_b     = b;
        in_m     = m;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < LAT + 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic sub, input op_t a, input op_t b,
                          input op_t m);
        int   lat;
        res_t exp;
        start_op(sub, a, b, m);
        check({name, " busy"}, res_t'(busy), res_t'(1));
        wait_done(lat);
        check({name, " latency"}, res_t'(lat), res_t'(LAT));
        check({name, " busy_at_done"}, res_t'(busy), res_t'(0));
        exp = exp_q.pop_front();
        check({name, " result"}, result, exp);
        @(negedge clk);
        check({name, " done_width"}, res_t'(done), res_t'(0));
        check({name, " hold"}, result, exp);
    endtask

    initial begin
        op_t  a, b, m, a2, b2;
        res_t exp1, exp2, got;
        int   lat, ndone;
        logic s;

`ifdef ADDER_MODRED_EN
        set_vec(0, 1'b0, op_t'(5), op_t'(4), op_t'(7), res_t'(2));
        set_vec(1, 1'b1, op_t'(3), op_t'(5), op_t'(7), res_t'(5));
        set_vec(2, 1'b0, op_t'(6), op_t'(6), op_t'(7), res_t'(5));
        set_vec(3, 1'b1, op_t'(6), op_t'(2), op_t'(7), res_t'(4));
        set_vec(4, 1'b0, op_t'(3), op_t'(3), op_t'(7), res_t'(6));
        set_vec(5, 1'b0, op_t'(0), op_t'(0), op_t'(7), res_t'(0));
        set_vec(6, 1'b1, op_t'(4), op_t'(4), op_t'(7), res_t'(0));
        set_vec(7, 1'b0, op_t'(1), op_t'(6), op_t'(7), res_t'(0));
`else
        set_vec(0, 1'b0, '1, op_t'(1), op_t'(7), res_t'(1) << WIDTH);
        set_vec(1, 1'b1, op_t'(0), op_t'(1), op_t'(7), '1);
        set_vec(2, 1'b1, op_t'(5), op_t'(3), op_t'(7), res_t'(2));
        set_vec(3, 1'b0, op_t'(0), op_t'(0), op_t'(7), res_t'(0));
        set_vec(4, 1'b0, op_t'(1) << (WIDTH - 1), op_t'(1) << (WIDTH - 1), op_t'(7),
                res_t'(1) << WIDTH);
        set_vec(5, 1'b1, '1, '1, op_t'(7), res_t'(0));
        set_vec(6, 1'b0, op_t'({64{1'b1}}), op_t'(1), op_t'(7), res_t'(1) << 64);
        set_vec(7, 1'b1, op_t'(1) << 64, op_t'(1), op_t'(7), res_t'({64{1'b1}}));
`endif

        // reset state
        resetn   = 1'b0;
        start    = 1'b0;
        subtract = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_m     = '0;
        repeat (3) @(negedge clk);
        check("reset result", result, res_t'(0));
        check("reset done", res_t'(done), res_t'(0));
        check("reset busy", res_t'(busy), res_t'(0));
        check("reset state", res_t'(state_dbg), res_t'(0));
        resetn = 1'b1;

        // directed vectors
        for (int i = 0; i < NVEC; i++) begin
            exp_q.push_back(tbl[i].exp);
            run_op($sformatf("vec%0d", i), tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].m);
        end

        // randomized against the reference model
        for (int i = 0; i < 12; i++) begin
            gen_ops(a, b, m);
            s = 1'($urandom_range(0, 1));
            exp_q.push_back(model(s, a, b, m));
            run_op($sformatf("rand%0d", i), s, a, b, m);
        end

        // start pulses while busy are ignored, input changes have no effect
        gen_ops(a, b, m);
        exp1 = model(1'b0, a, b, m);
        start_op(1'b0, a, b, m);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            gen_ops(a2, b2, in_m);
            in_a     = a2;
            in_b     = b2;
            subtract = 1'b1;
            start    = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        ndone = 0;
        got   = '0;
        for (int k = 0; k < LAT + 6; k++) begin
            if (done) begin
                ndone++;
                got = result;
            end
            @(negedge clk);
        end
        check("busy_start done_count", res_t'(ndone), res_t'(1));
        check("busy_start result", got, exp1);

        // reset mid-operation aborts at once, no done pulse
        gen_ops(a, b, m);
        start_op(1'b0, a, b, m);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("abort result", result, res_t'(0));
        check("abort busy", res_t'(busy), res_t'(0));
        check("abort done", res_t'(done), res_t'(0));
        check("abort state", res_t'(state_dbg), res_t'(0));
        ndone = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < LAT + 4; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("abort no_done", res_t'(ndone), res_t'(0));
        gen_ops(a, b, m);
        exp_q.push_back(model(1'b1, a, b, m));
        run_op("after_abort", 1'b1, a, b, m);

        // start in the done cycle: back-to-back operations
        gen_ops(a, b, m);
        exp1 = model(1'b0, a, b, m);
        start_op(1'b0, a, b, m);
        wait_done(lat);
        check("b2b first latency", res_t'(lat), res_t'(LAT));
        check("b2b first result", result, exp1);
        gen_ops(a2, b2, m);
        exp2     = model(1'b1, a2, b2, m);
        subtract = 1'b1;
        in_a     = a2;
        in_b     = b2;
        in_m     = m;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        check("b2b second busy", res_t'(busy), res_t'(1));
        wait_done(lat);
        check("b2b second latency", res_t'(lat), res_t'(LAT));
        check("b2b second result", result, exp2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
